mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Multicycle word memory slave with fixed wait-state latency and a one-cycle ready pulse.
// Optional alignment/range check is enabled with the MEM_ALIGN_CHECK_EN macro.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    // state | meaning
    // IDLE  | waiting for mem_read/mem_write
    // WAIT  | request captured, counting down wait states
    // DONE  | access performed, ready pulse for one cycle
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, stateNext;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] idxQ;
    logic [31:0]       wdataQ;
    logic              opWrite;
    logic              errQ;
    logic              errNow;
    logic              accept;
    logic              access;
    logic [31:0]       memArray [DEPTH];

`ifdef MEM_ALIGN_CHECK_EN
    assign errNow  = (addr[1:0] != 2'b00) | (addr[31:ADDR_W+2] != '0);
    assign mem_err = mem_ready & errQ;
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};
    assign errNow  = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign accept    = (state == IDLE) && (mem_read || mem_write);
    assign access    = (state == WAIT) && (waitCnt == 4'd0);
    assign mem_ready = (state == DONE);
    assign mem_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (mem_read || mem_write) stateNext = WAIT;
            WAIT:    if (waitCnt == 4'd0) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt <= 4'd0;
            idxQ    <= '0;
            wdataQ  <= 32'd0;
            opWrite <= 1'b0;
            errQ    <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            if (accept) begin
                idxQ    <= addr[ADDR_W+1:2];
                wdataQ  <= wdata;
                opWrite <= mem_write;   // write wins when both are requested
                errQ    <= errNow;
                waitCnt <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (access && !opWrite && !errQ) rdata <= memArray[idxQ];
        end
    end

    // Array has no reset; the !reset term drops a write whose completion edge sees reset.
    always_ff @(posedge clk) begin
        if (!reset && access && opWrite && !errQ) memArray[idxQ] <= wdataQ;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance checked by a monitor, LATENCY=1 instance checked inline.
module tb_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_read, mem_write, mem_ready, mem_busy, mem_err;
    logic [31:0] addr, wdata, rdata;
    logic        rd1, wr1, ready1, busy1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready),
        .mem_busy(mem_busy), .mem_err(mem_err));

    mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .mem_ready(ready1),
        .mem_busy(busy1), .mem_err(err1));

    typedef struct {
        bit          isRead;
        bit          err;
        logic [31:0] data;
        int          readyCyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monExp;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          busyCnt = 0;
    logic [31:0] lastRd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready pulse
    always @(negedge clk) begin
        if (!mem_busy) busyCnt = 0;
        else busyCnt++;
        if (!reset && mem_busy && sbq.size() > 0 && !sbq[0].isRead)
            chk("rdata_held_during_write", rdata, lastRd);
        if (!reset && mem_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                monExp = sbq.pop_front();
                chk("ready_cycle", cyc, monExp.readyCyc);
                chk("busy_cycles", busyCnt, 32'd3);
                chk("mem_err", {31'd0, mem_err}, {31'd0, monExp.err});
                if (monExp.isRead) begin
                    if (monExp.err) chk("rdata_err_held", rdata, lastRd);
                    else begin
                        chk("rdata", rdata, monExp.data);
                        lastRd = monExp.data;
                    end
                end
            end
        end
    end

    // Called at the negedge before the accepting edge
    task automatic pushExp(input bit isRd, input bit err, input logic [31:0] d);
        sbq.push_back('{isRead: isRd, err: err, data: d, readyCyc: cyc + 3});
    endtask

    task automatic doOp(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit err, input logic [31:0] expData);
        int n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        pushExp(rd && !wr, err, expData);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'h0;
        n = 0;
        while (!mem_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_busy", {31'd0, mem_busy}, 32'd0);
        chk("reset_err", {31'd0, mem_err}, 32'd0);
        reset = 1'b0;

        doOp(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
        doOp(1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);

        doOp(1, 1, 32'h20, 32'h1234_5678, 0, 32'h0);
        doOp(1, 0, 32'h20, 32'h0, 0, 32'h1234_5678);

        for (int i = 0; i < 4; i++) doOp(0, 1, 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 32'h0);
        doOp(0, 1, 32'hFC, 32'h5A5A_5A5A, 0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem_read = 1'b1; addr = 32'(4 * i);
            pushExp(1, 0, 32'h1000_0000 + 32'(i));
            @(negedge clk);
            addr = 32'hFC;
            repeat (2) @(negedge clk);
            if (i == 3) mem_read = 1'b0;
            @(negedge clk);
        end

        doOp(0, 1, 32'h30, 32'h1111_2222, 0, 32'h0);
        doOp(1, 0, 32'h30, 32'h0, 0, 32'h1111_2222);
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h30; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_write = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rdata_after_reset", rdata, 32'd0);
        chk("busy_after_reset", {31'd0, mem_busy}, 32'd0);
        lastRd = 32'd0;
        repeat (4) @(negedge clk);
        doOp(1, 0, 32'h30, 32'h0, 0, 32'h1111_2222);

        doOp(0, 1, 32'h31, 32'hAAAA_5555, ALIGN, 32'h0);
        doOp(1, 0, 32'h30, 32'h0, 0, ALIGN ? 32'h1111_2222 : 32'hAAAA_5555);
        doOp(0, 1, 32'h400, 32'hBBBB_6666, ALIGN, 32'h0);
        doOp(1, 0, 32'h0, 32'h0, 0, ALIGN ? 32'h1000_0000 : 32'hBBBB_6666);
        doOp(1, 0, 32'h402, 32'h0, ALIGN, 32'hBBBB_6666);

        @(negedge clk);
        wr1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h0BAD_CAFE;
        @(negedge clk);
        wr1 = 1'b0;
        chk("lat1_wr_busy", {31'd0, busy1}, 32'd1);
        chk("lat1_wr_not_ready", {31'd0, ready1}, 32'd0);
        @(negedge clk);
        chk("lat1_wr_ready", {31'd0, ready1}, 32'd1);
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h4;
        @(negedge clk);
        rd1 = 1'b0;
        chk("lat1_rd_not_ready", {31'd0, ready1}, 32'd0);
        @(negedge clk);
        chk("lat1_rd_ready", {31'd0, ready1}, 32'd1);
        chk("lat1_rd_err", {31'd0, err1}, 32'd0);
        chk("lat1_rdata", rdata1, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("lat1_idle", {31'd0, busy1}, 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
